// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared FSM state codes and default widths for the up/down sweep controller.
package updown_sweep_ctrl_pkg;

    localparam int DEF_W  = 8;
    localparam int DEF_HW = 4;
    localparam int DEF_SW = 4;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_UP      = 3'd1;
    localparam logic [2:0] ST_HOLD_HI = 3'd2;
    localparam logic [2:0] ST_DOWN    = 3'd3;
    localparam logic [2:0] ST_HOLD_LO = 3'd4;

endpackage

// File: rtl/sweep_hold_timer.sv
// Endpoint dwell timer: load with the hold count on entry to a hold state, tick once per held cycle.
// expire is combinational and goes high on the last held cycle, so the hold lasts exactly load_val cycles.
module sweep_hold_timer
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int HW = DEF_HW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [HW-1:0] load_val,
    input  logic          tick,
    output logic          expire
);

    logic [HW-1:0] remain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remain <= '0;
        end else if (load) begin
            remain <= load_val;
        end else if (tick && (remain != '0)) begin
            remain <= remain - 1'b1;
        end
    end

    assign expire = (remain <= HW'(1));

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: counts lo..hi..lo with optional endpoint dwell, for a set number of sweeps.
// Start takes effect on the sampling edge; stop aborts on the next edge with count frozen.
module updown_sweep_ctrl
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int HW = DEF_HW,
    parameter int SW = DEF_SW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [HW-1:0] hold,
    input  logic [SW-1:0] sweeps,
    output logic [W-1:0]  count,
    output logic          dir,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    state_t        state, state_nxt;
    logic [W-1:0]  lo_r, hi_r, count_nxt, count_inc, count_dec;
    logic [HW-1:0] hold_r;
    logic [SW-1:0] sweeps_r, sweep_cnt, sweep_nxt, sweep_inc;
    logic          done_nxt, err_nxt, latch_cfg;
    logic          tmr_load, tmr_tick, tmr_expire;

    assign count_inc = count + 1'b1;
    assign count_dec = count - 1'b1;
    // Saturates so an endless program (sweeps_r == 0) never wraps back to a small count.
    assign sweep_inc = (sweep_cnt == '1) ? sweep_cnt : sweep_cnt + 1'b1;

    assign busy = (state != ST_IDLE);
    assign dir  = !((state == ST_DOWN) || (state == ST_HOLD_LO));

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        sweep_nxt = sweep_cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        latch_cfg = 1'b0;
        tmr_load  = 1'b0;
        tmr_tick  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (lo < hi) begin
                        latch_cfg = 1'b1;
                        count_nxt = lo;
                        sweep_nxt = '0;
                        state_nxt = ST_UP;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_UP: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    count_nxt = count_inc;
                    if (count_inc == hi_r) begin
                        tmr_load  = (hold_r != '0);
                        state_nxt = (hold_r != '0) ? ST_HOLD_HI : ST_DOWN;
                    end
                end
            end
            ST_HOLD_HI: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tmr_tick = 1'b1;
                    if (tmr_expire) state_nxt = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    count_nxt = count_dec;
                    if (count_dec == lo_r) begin
                        sweep_nxt = sweep_inc;
                        if ((sweeps_r != '0) && (sweep_inc == sweeps_r)) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            tmr_load  = (hold_r != '0);
                            state_nxt = (hold_r != '0) ? ST_HOLD_LO : ST_UP;
                        end
                    end
                end
            end
            ST_HOLD_LO: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tmr_tick = 1'b1;
                    if (tmr_expire) state_nxt = ST_UP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            sweep_cnt <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            lo_r      <= '0;
            hi_r      <= '0;
            hold_r    <= '0;
            sweeps_r  <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            sweep_cnt <= sweep_nxt;
            done      <= done_nxt;
            cfg_err   <= err_nxt;
            if (latch_cfg) begin
                lo_r     <= lo;
                hi_r     <= hi;
                hold_r   <= hold;
                sweeps_r <= sweeps;
            end
        end
    end

    sweep_hold_timer #(.HW(HW)) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (hold_r),
        .tick     (tmr_tick),
        .expire   (tmr_expire)
    );

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Randomized bench for updown_sweep_ctrl against a sweep-level reference sequence.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] lo_in = '0, hi_in = '0;
    logic [3:0] hold_in = '0, sweeps_in = '0;
    logic [7:0] count;
    logic       dir, busy, done, cfg_err;

    int n_chk = 0;
    int n_fail = 0;
    int model_count = 0;

    typedef struct {
        int cnt;
        bit d;
        bit b;
        bit dn;
    } exp_t;

    exp_t q[$];

    updown_sweep_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .lo      (lo_in),
        .hi      (hi_in),
        .hold    (hold_in),
        .sweeps  (sweeps_in),
        .count   (count),
        .dir     (dir),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(int c, bit d, bit b, bit dn);
        exp_t e;
        e.cnt = c; e.d = d; e.b = b; e.dn = dn;
        q.push_back(e);
    endfunction

    // Per-cycle expectation after the start edge, built sweep by sweep.
    function automatic void gen(int lo, int hi, int hold, int sw, int maxlen);
        q.delete();
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) for (int j = 0; j < hold; j++) push(lo, 0, 1, 0);
            for (int v = lo; v < hi; v++) push(v, 1, 1, 0);
            for (int j = 0; j < hold; j++) push(hi, 1, 1, 0);
            for (int v = hi; v > lo; v--) push(v, 0, 1, 0);
            if (sw != 0 && k + 1 == sw) begin
                push(lo, 1, 0, 1);
                return;
            end
            if (sw == 0 && q.size() >= maxlen) return;
        end
    endfunction

    function automatic int find(int c, bit d);
        for (int i = 0; i < q.size(); i++)
            if (q[i].cnt == c && q[i].d == d) return i;
        return 0;
    endfunction

    task automatic check_out(input exp_t e);
        check("count", 32'(count), e.cnt);
        check("dir", 32'(dir), 32'(e.d));
        check("busy", 32'(busy), 32'(e.b));
        check("done", 32'(done), 32'(e.dn));
        check("cfg_err", 32'(cfg_err), 0);
    endtask

    task automatic run_prog(input int lo, input int hi, input int hold, input int sw,
                            input int stop_at, input int rst_at);
        lo_in = 8'(lo); hi_in = 8'(hi); hold_in = 4'(hold); sweeps_in = 4'(sw);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            check_out(q[i]);
            model_count = q[i].cnt;
            if (i == stop_at) begin
                start = 1'b0;
                stop = 1'b1;
                step();
                stop = 1'b0;
                check("stop_busy", 32'(busy), 0);
                check("stop_count", 32'(count), model_count);
                check("stop_done", 32'(done), 0);
                check("stop_dir", 32'(dir), 1);
                step();
                check("stop_hold_count", 32'(count), model_count);
                check("stop_hold_busy", 32'(busy), 0);
                return;
            end
            if (i == rst_at) begin
                start = 1'b0;
                #2 reset = 1'b0;
                #1;
                check("arst_count", 32'(count), 0);
                check("arst_dir", 32'(dir), 1);
                check("arst_busy", 32'(busy), 0);
                check("arst_done", 32'(done), 0);
                check("arst_cfg_err", 32'(cfg_err), 0);
                model_count = 0;
                @(posedge clk);
                #2 reset = 1'b1;
                step();
                check("post_rst_busy", 32'(busy), 0);
                check("post_rst_count", 32'(count), 0);
                return;
            end
            if (i < q.size() - 1) begin
                // Start and configuration changes while busy must have no effect.
                start = 1'($urandom);
                lo_in = 8'($urandom); hi_in = 8'($urandom);
                hold_in = 4'($urandom); sweeps_in = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
        end
        check("end_done", 32'(done), 0);
        check("end_busy", 32'(busy), 0);
        check("end_count", 32'(count), lo);
        model_count = lo;
    endtask

    initial begin
        int lo, hi, hold, sw, stop_at, idx;
        #1 reset = 1'b0;
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_dir", 32'(dir), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        step();
        step();
        @(negedge clk) reset = 1'b1;
        step();
        check("idle_busy", 32'(busy), 0);

        gen(3, 6, 1, 1, 0);
        run_prog(3, 6, 1, 1, -1, -1);
        gen(0, 2, 0, 2, 0);
        run_prog(0, 2, 0, 2, -1, -1);

        lo_in = 8'd5; hi_in = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        check("err_pulse", 32'(cfg_err), 1);
        check("err_busy", 32'(busy), 0);
        check("err_count", 32'(count), model_count);
        step();
        check("err_clear", 32'(cfg_err), 0);
        check("err_busy2", 32'(busy), 0);

        lo_in = 8'd200; hi_in = 8'd10; start = 1'b1;
        step();
        start = 1'b0;
        check("err_rev_pulse", 32'(cfg_err), 1);
        check("err_rev_count", 32'(count), model_count);

        gen(250, 255, 0, 0, 200);
        run_prog(250, 255, 0, 0, find(253, 0), -1);

        gen(0, 1, 0, 0, 60);
        run_prog(0, 1, 0, 0, 59, -1);

        gen(3, 6, 3, 1, 0);
        idx = find(6, 1);
        run_prog(3, 6, 3, 1, -1, idx + 1);
        gen(3, 6, 1, 1, 0);
        run_prog(3, 6, 1, 1, -1, -1);

        lo_in = 8'd1; hi_in = 8'd9; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", 32'(busy), 0);
        check("ss_count", 32'(count), model_count);
        check("ss_cfg_err", 32'(cfg_err), 0);
        step();
        check("ss_busy2", 32'(busy), 0);

        for (int n = 0; n < 40; n++) begin
            hi = $urandom_range(1, 20);
            lo = (n % 5 == 0) ? 255 - hi : $urandom_range(0, 230);
            hi = lo + hi;
            hold = $urandom_range(0, 3);
            sw = $urandom_range(0, 3);
            gen(lo, hi, hold, sw, 120);
            stop_at = -1;
            if (sw == 0 || $urandom_range(0, 3) == 0)
                stop_at = $urandom_range(0, q.size() - 2);
            run_prog(lo, hi, hold, sw, stop_at, -1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
